// File: rtl/zcycle_timer.sv
// Memory cycle phase generator for the fclk domain: pre_cend/cend strobes, pair select,
// and a turbo request stager that only lets a stable, legal turbo code change at a pair end.
module zcycle_timer #(
  parameter int PHASE_BITS  = 2,
  parameter int TURBO_DWELL = 16,
  parameter bit ALLOW_14    = 1'b0
) (
  input  logic                  fclk,
  input  logic                  rst_n,
  input  logic [1:0]            turbo_in,
  input  logic                  resync,
  output logic [PHASE_BITS-1:0] phase,
  output logic                  pre_cend,
  output logic                  cend,
  output logic                  half_sel,
  output logic [1:0]            turbo,
  output logic                  turbo_chg,
  output logic                  turbo_pend
);

  localparam int CNT_W = (TURBO_DWELL > 0) ? $clog2(TURBO_DWELL + 1) : 1;
  localparam logic [PHASE_BITS-1:0] PH_LAST = '1;
  localparam logic [PHASE_BITS-1:0] PH_PRE  = PH_LAST - PHASE_BITS'(1);
  localparam logic [CNT_W-1:0]      CNT_MAX = CNT_W'(TURBO_DWELL);

  logic [PHASE_BITS-1:0] next_phase;
  logic [1:0]            req;
  logic [1:0]            candidate;
  logic [CNT_W-1:0]      cnt;
  logic                  apply;

  // Strobes are registered from the next-phase decode so they line up exactly with phase.
  always_comb begin
    next_phase = resync ? '0 : phase + PHASE_BITS'(1);
    req        = (!ALLOW_14 && turbo_in[1]) ? 2'b01 : turbo_in;
    turbo_pend = (cnt == CNT_MAX) && (candidate != turbo);
    apply      = cend && half_sel && turbo_pend;
  end

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      phase    <= '0;
      pre_cend <= 1'b0;
      cend     <= 1'b0;
      half_sel <= 1'b0;
    end else begin
      phase    <= next_phase;
      pre_cend <= !resync && (next_phase == PH_PRE);
      cend     <= !resync && (next_phase == PH_LAST);
      if (resync) begin
        half_sel <= 1'b0;
      end else if (cend) begin
        half_sel <= !half_sel;
      end
    end
  end

  // A request must sit unchanged for TURBO_DWELL edges before it may be applied.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      candidate <= 2'b00;
      cnt       <= '0;
    end else if (req != candidate) begin
      candidate <= req;
      cnt       <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Applying only at the end of the second cycle keeps turbo constant across a whole pair.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      turbo     <= 2'b00;
      turbo_chg <= 1'b0;
    end else begin
      turbo_chg <= apply;
      if (apply) begin
        turbo <= candidate;
      end
    end
  end

endmodule

// File: tb/tb_zcycle_timer.sv
// Self-checking bench for zcycle_timer: a cycle model feeds a scoreboard queue, and each
// scenario task adds directed checks of latencies and pulse counts.
module tb_zcycle_timer;

  localparam int N     = 4;
  localparam int DWELL = 16;

  logic       fclk     = 1'b0;
  logic       rst_n    = 1'b1;
  logic [1:0] turbo_in = 2'b00;
  logic       resync   = 1'b0;
  logic [1:0] phase;
  logic       pre_cend;
  logic       cend;
  logic       half_sel;
  logic [1:0] turbo;
  logic       turbo_chg;
  logic       turbo_pend;

  typedef struct packed {
    logic [1:0] phase;
    logic       pre;
    logic       cend;
    logic       half;
    logic [1:0] turbo;
    logic       chg;
    logic       pend;
  } obs_t;

  obs_t sbq[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  int         m_phase;
  int         m_cnt;
  logic       m_pre;
  logic       m_cend;
  logic       m_half;
  logic       m_chg;
  logic [1:0] m_turbo;
  logic [1:0] m_cand;

  zcycle_timer #(
    .PHASE_BITS (2),
    .TURBO_DWELL(DWELL),
    .ALLOW_14   (1'b0)
  ) dut (
    .fclk      (fclk),
    .rst_n     (rst_n),
    .turbo_in  (turbo_in),
    .resync    (resync),
    .phase     (phase),
    .pre_cend  (pre_cend),
    .cend      (cend),
    .half_sel  (half_sel),
    .turbo     (turbo),
    .turbo_chg (turbo_chg),
    .turbo_pend(turbo_pend)
  );

  always #5 fclk = ~fclk;

  task automatic model_reset();
    m_phase = 0;
    m_cnt   = 0;
    m_pre   = 1'b0;
    m_cend  = 1'b0;
    m_half  = 1'b0;
    m_chg   = 1'b0;
    m_turbo = 2'b00;
    m_cand  = 2'b00;
  endtask

  function automatic logic model_pend();
    return (m_cnt == DWELL) && (m_cand != m_turbo);
  endfunction

  // One fclk: advance the model at the edge, queue its prediction, compare at the falling edge.
  task automatic tick();
    obs_t       e;
    obs_t       a;
    logic [1:0] req;
    logic       pend_old;
    logic       cend_old;
    logic       half_old;
    @(posedge fclk);
    cyc++;
    if (!rst_n) begin
      model_reset();
    end else begin
      req      = turbo_in[1] ? 2'b01 : turbo_in;
      pend_old = model_pend();
      cend_old = m_cend;
      half_old = m_half;
      m_phase  = resync ? 0 : (m_phase + 1) % N;
      m_pre    = !resync && (m_phase == N - 2);
      m_cend   = !resync && (m_phase == N - 1);
      if (resync) m_half = 1'b0;
      else if (cend_old) m_half = !m_half;
      m_chg = cend_old && half_old && pend_old;
      if (m_chg) m_turbo = m_cand;
      if (req != m_cand) begin
        m_cand = req;
        m_cnt  = 0;
      end else if (m_cnt < DWELL) begin
        m_cnt++;
      end
    end
    e = {2'(m_phase), m_pre, m_cend, m_half, m_turbo, m_chg, model_pend()};
    sbq.push_back(e);
    @(negedge fclk);
    e = sbq.pop_front();
    a = {phase, pre_cend, cend, half_sel, turbo, turbo_chg, turbo_pend};
    tests++;
    if (a !== e) begin
      fails++;
      $display("[TB] FAIL scoreboard cycle %0d: got ph=%0d pre=%b cend=%b half=%b turbo=%b chg=%b pend=%b, expected ph=%0d pre=%b cend=%b half=%b turbo=%b chg=%b pend=%b",
               cyc, a.phase, a.pre, a.cend, a.half, a.turbo, a.chg, a.pend,
               e.phase, e.pre, e.cend, e.half, e.turbo, e.chg, e.pend);
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    tests++;
    if ({phase, pre_cend, cend, half_sel, turbo, turbo_chg, turbo_pend} !== 9'b0) begin
      fails++;
      $display("[TB] FAIL reset_state: got %b, expected %b",
               {phase, pre_cend, cend, half_sel, turbo, turbo_chg, turbo_pend}, 9'b0);
    end
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_free_run();
    int   n_pre  = 0;
    int   n_cend = 0;
    int   n_chg  = 0;
    int   n_tog  = 0;
    int   bad_ph = 0;
    logic prev_half;
    turbo_in  = 2'b00;
    prev_half = half_sel;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (pre_cend) begin
        n_pre++;
        if (phase !== 2'd2) bad_ph++;
      end
      if (cend) begin
        n_cend++;
        if (phase !== 2'd3) bad_ph++;
      end
      if (turbo_chg) n_chg++;
      if (half_sel !== prev_half) n_tog++;
      prev_half = half_sel;
    end
    tests++;
    if (n_pre != 4) begin
      fails++;
      $display("[TB] FAIL free_pre_count: got %0d, expected 4", n_pre);
    end
    tests++;
    if (n_cend != 4) begin
      fails++;
      $display("[TB] FAIL free_cend_count: got %0d, expected 4", n_cend);
    end
    tests++;
    if (bad_ph != 0) begin
      fails++;
      $display("[TB] FAIL free_strobe_phase: got %0d misplaced strobes, expected 0", bad_ph);
    end
    tests++;
    if (n_tog != 4) begin
      fails++;
      $display("[TB] FAIL free_half_toggles: got %0d, expected 4", n_tog);
    end
    tests++;
    if (n_chg != 0 || turbo !== 2'b00) begin
      fails++;
      $display("[TB] FAIL free_turbo_idle: got chg=%0d turbo=%b, expected 0 and 00", n_chg, turbo);
    end
  endtask

  task automatic test_dwell_glitch();
    int n_pend = 0;
    int n_bad  = 0;
    for (int i = 0; i < 100; i++) begin
      if (i % 10 == 0) turbo_in = ((i / 10) % 2 == 1) ? 2'b00 : 2'b01;
      tick();
      if (turbo_pend) n_pend++;
      if (turbo !== 2'b00) n_bad++;
    end
    tests++;
    if (n_pend != 0 || n_bad != 0) begin
      fails++;
      $display("[TB] FAIL dwell_glitch: got pend_cycles=%0d turbo_changed_cycles=%0d, expected 0 and 0", n_pend, n_bad);
    end
  endtask

  task automatic test_apply();
    int k_pend = -1;
    int k_chg  = -1;
    int n_chg  = 0;
    turbo_in = 2'b01;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (turbo_pend) begin
        k_pend = k;
        break;
      end
    end
    tests++;
    if (k_pend != DWELL + 1) begin
      fails++;
      $display("[TB] FAIL apply_pend_latency: got %0d, expected %0d", k_pend, DWELL + 1);
    end
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (turbo_chg) begin
        k_chg = k;
        break;
      end
    end
    tests++;
    if (k_chg < 1 || k_chg > 8 || turbo !== 2'b01) begin
      fails++;
      $display("[TB] FAIL apply_change: got wait=%0d turbo=%b, expected wait 1..8 turbo=01", k_chg, turbo);
    end
    for (int k = 0; k < 20; k++) begin
      tick();
      if (turbo_chg) n_chg++;
    end
    tests++;
    if (n_chg != 0 || turbo !== 2'b01) begin
      fails++;
      $display("[TB] FAIL apply_single_pulse: got extra=%0d turbo=%b, expected 0 and 01", n_chg, turbo);
    end
  endtask

  task automatic test_clamp();
    int k_pend = -1;
    int n_chg  = 0;
    int n_pend = 0;
    bit seen   = 1'b0;
    turbo_in = 2'b00;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (turbo_chg) begin
        seen = 1'b1;
        break;
      end
    end
    tests++;
    if (!seen || turbo !== 2'b00) begin
      fails++;
      $display("[TB] FAIL clamp_revert: got seen=%0d turbo=%b, expected 1 and 00", seen, turbo);
    end
    turbo_in = 2'b11;
    for (int k = 1; k <= 40; k++) begin
      if (k == 11) turbo_in = 2'b10;
      tick();
      if (turbo_pend && k_pend < 0) k_pend = k;
      if (turbo_chg) n_chg++;
    end
    tests++;
    if (k_pend != DWELL + 1) begin
      fails++;
      $display("[TB] FAIL clamp_no_restart: got pend at %0d, expected %0d", k_pend, DWELL + 1);
    end
    tests++;
    if (n_chg != 1 || turbo !== 2'b01) begin
      fails++;
      $display("[TB] FAIL clamp_result: got chg=%0d turbo=%b, expected 1 and 01", n_chg, turbo);
    end
    n_chg    = 0;
    turbo_in = 2'b11;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (turbo_chg) n_chg++;
      if (turbo_pend) n_pend++;
    end
    tests++;
    if (n_chg != 0 || n_pend != 0) begin
      fails++;
      $display("[TB] FAIL clamp_same_request: got chg=%0d pend=%0d, expected 0 and 0", n_chg, n_pend);
    end
  endtask

  task automatic test_resync();
    bit found = 1'b0;
    int k_chg = -1;
    for (int k = 0; k < 16 && !(phase == 2'd0 && half_sel == 1'b0); k++) tick();
    turbo_in = 2'b00;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (turbo_pend && half_sel && phase == 2'd1) begin
        found = 1'b1;
        break;
      end
    end
    tests++;
    if (!found) begin
      fails++;
      $display("[TB] FAIL resync_setup: got no pending request at phase 1 half 1, expected one");
    end
    resync = 1'b1;
    tick();
    resync = 1'b0;
    tests++;
    if ({phase, half_sel, pre_cend, cend, turbo, turbo_pend} !== 8'b00_0_0_0_01_1) begin
      fails++;
      $display("[TB] FAIL resync_state: got ph=%0d half=%b pre=%b cend=%b turbo=%b pend=%b, expected 0 0 0 0 01 1",
               phase, half_sel, pre_cend, cend, turbo, turbo_pend);
    end
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (turbo_chg) begin
        k_chg = k;
        break;
      end
    end
    tests++;
    if (k_chg != 8 || turbo !== 2'b00) begin
      fails++;
      $display("[TB] FAIL resync_apply: got wait=%0d turbo=%b, expected 8 and 00", k_chg, turbo);
    end
  endtask

  task automatic test_async_reset();
    bit found  = 1'b0;
    int n_pend = 0;
    int k_pend = -1;
    for (int k = 0; k < 16 && !(phase == 2'd0 && half_sel == 1'b0); k++) tick();
    turbo_in = 2'b01;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (turbo_pend && cend && phase == 2'd3) begin
        found = 1'b1;
        break;
      end
    end
    tests++;
    if (!found) begin
      fails++;
      $display("[TB] FAIL areset_setup: got no pending request at phase 3 with cend, expected one");
    end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    tests++;
    if ({phase, pre_cend, cend, half_sel, turbo, turbo_chg, turbo_pend} !== 9'b0) begin
      fails++;
      $display("[TB] FAIL areset_immediate: got %b, expected %b",
               {phase, pre_cend, cend, half_sel, turbo, turbo_chg, turbo_pend}, 9'b0);
    end
    tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (turbo_pend && k_pend < 0) k_pend = k;
      if (k <= DWELL && (turbo_pend || turbo !== 2'b00)) n_pend++;
    end
    tests++;
    if (n_pend != 0 || k_pend != DWELL + 1) begin
      fails++;
      $display("[TB] FAIL areset_discard: got early=%0d pend_at=%0d, expected 0 and %0d", n_pend, k_pend, DWELL + 1);
    end
  endtask

  task automatic test_back_to_back();
    int n_bad = 0;
    resync = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      if ({phase, pre_cend, cend, half_sel} !== 5'b0) n_bad++;
    end
    resync = 1'b0;
    tick();
    tests++;
    if (n_bad != 0 || phase !== 2'd1) begin
      fails++;
      $display("[TB] FAIL back_to_back_resync: got bad=%0d phase=%0d, expected 0 and 1", n_bad, phase);
    end
    tick();
    tick();
    tests++;
    if (cend !== 1'b1 || pre_cend !== 1'b0) begin
      fails++;
      $display("[TB] FAIL back_to_back_cend: got cend=%b pre=%b, expected 1 and 0", cend, pre_cend);
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_dwell_glitch();
    test_apply();
    test_clamp();
    test_resync();
    test_async_reset();
    test_back_to_back();
    tests++;
    if (sbq.size() != 0) begin
      fails++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries left, expected 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
